keypad_scan_ctrl: RTL and testbench



---
 rtl/keypad_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with sweep debounce, ghost rejection and key-event FIFO
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   row        raw row returns, active-high, asynchronous to clk
//   col        column drive, one-hot while scanning, all ones otherwise
//   key_code   FIFO head code, 4*row_index + col_index
//   key_valid  FIFO not empty
//   key_rd     one-cycle pop strobe, ignored when empty
//   key_down   accepted key still held
//   overflow   sticky, a press was dropped on a full FIFO
//   ovf_clr    clears overflow (a simultaneous set wins)
module keypad_scan_ctrl #(
    parameter int CLK_DIV    = 1000,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_rd,
    output logic       key_down,
    output logic       overflow,
    input  logic       ovf_clr
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t        state, state_next;
    logic [3:0]    row_meta, rs;
    logic [PW-1:0] pre;
    logic          tick;
    logic [1:0]    col_idx;
    logic          hit, ghost;
    logic [3:0]    code, cand;
    logic [DW-1:0] deb_cnt, rel_cnt, deb_inc, rel_inc;
    logic          one_hot, multi;
    logic [1:0]    row_idx;
    logic [3:0]    samp_code, fin_code;
    logic          sweep_end, fin_hit, fin_ghost, accept, released;
    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, pop, wr, ovf_set;

    // Row returns are asynchronous; every decision uses the synchronized copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= '0;
            rs       <= '0;
        end else begin
            row_meta <= row;
            rs       <= row_meta;
        end
    end

    assign tick = pre == PW'(CLK_DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre <= '0;
        else
            pre <= tick ? '0 : pre + 1'b1;
    end

    // Per-tick sample decode and end-of-sweep evaluation.
    always_comb begin
        one_hot   = (rs != '0) && ((rs & (rs - 4'd1)) == '0);
        multi     = (rs != '0) && !one_hot;
        row_idx   = rs[1] ? 2'd1 : rs[2] ? 2'd2 : rs[3] ? 2'd3 : 2'd0;
        samp_code = {row_idx, col_idx};
        sweep_end = (state == SCAN) && tick && (col_idx == 2'd3);
        // A second single-bit hit in the same sweep is as ambiguous as a multi-bit sample.
        fin_ghost = ghost || multi || (one_hot && hit);
        fin_hit   = hit || one_hot;
        fin_code  = hit ? code : samp_code;
        deb_inc   = (fin_code == cand) ? deb_cnt + 1'b1 : DW'(1);
        accept    = sweep_end && !fin_ghost && fin_hit && (deb_inc == DW'(DEBOUNCE));
        rel_inc   = rel_cnt + 1'b1;
        released  = (state == HOLD) && tick && (rs == '0) && (rel_inc == DW'(DEBOUNCE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = (state == IDLE && tick && rs != '0)     ? SCAN :
                     (sweep_end && !fin_ghost && !fin_hit)   ? IDLE :
                     accept                                  ? HOLD :
                     released                                ? IDLE : state;
    end

    always_comb begin
        col      = (state == SCAN) ? 4'b0001 << col_idx : 4'b1111;
        key_down = state == HOLD;
    end

    // Sweep bookkeeping. col_idx wraps from 3 to 0, which restarts the sweep
    // or leaves it parked at 0 when the controller drops back to IDLE or HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_idx <= '0;
            hit     <= 1'b0;
            ghost   <= 1'b0;
            code    <= '0;
            cand    <= '0;
            deb_cnt <= '0;
            rel_cnt <= '0;
        end else if (tick) begin
            if (state == IDLE) begin
                col_idx <= '0;
                hit     <= 1'b0;
                ghost   <= 1'b0;
            end else if (state == SCAN) begin
                col_idx <= col_idx + 2'd1;
                if (sweep_end) begin
                    hit     <= 1'b0;
                    ghost   <= 1'b0;
                    cand    <= (!fin_ghost && fin_hit) ? fin_code : cand;
                    deb_cnt <= (fin_ghost || !fin_hit || accept) ? '0 : deb_inc;
                end else begin
                    hit   <= fin_hit;
                    ghost <= fin_ghost;
                    code  <= fin_code;
                end
            end else begin
                rel_cnt <= (rs != '0 || released) ? '0 : rel_inc;
            end
        end
    end

    // Event FIFO: a pop frees the slot a same-cycle push needs, so a full
    // FIFO only drops the press when nothing is read in that cycle.
    always_comb begin
        full    = count == CW'(FIFO_DEPTH);
        pop     = key_rd && (count != '0);
        wr      = accept && (!full || pop);
        ovf_set = accept && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= fin_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr   <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count    <= count + CW'(wr) - CW'(pop);
            overflow <= ovf_set ? 1'b1 : ovf_clr ? 1'b0 : overflow;
        end
    end

    assign key_valid = count != '0;
    assign key_code  = key_valid ? mem[rd_ptr] : 4'd0;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed bench with a sweep-level keypad model and per-cycle output compare
module tb_keypad_scan_ctrl;
    localparam int CLK_DIV    = 4;
    localparam int DEBOUNCE   = 2;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row, col, key_code;
    logic        key_valid, key_down, overflow;
    logic        key_rd = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [15:0] keys = '0;
    int          checks = 0;
    int          errors = 0;

    keypad_scan_ctrl #(
        .CLK_DIV(CLK_DIV),
        .DEBOUNCE(DEBOUNCE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .row(row),
        .col(col),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_rd(key_rd),
        .key_down(key_down),
        .overflow(overflow),
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key (code 4*r+c) shorts column c onto row r.
    always_comb begin
        row = '0;
        for (int r = 0; r < 4; r++)
            row[r] = |(keys[4*r +: 4] & col);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: works per tick on whole sweeps. A sweep is four column samples;
    // exactly one set bit over the sweep is a hit, more than one is a ghost.
    int         m_pc, m_mode, m_pos, m_streak, m_last, m_quiet, m_total, m_code;
    bit         m_ovf, m_tick, m_push, m_drop;
    logic [3:0] m_s1, m_s2, m_rs;
    logic [3:0] m_samp [4];
    int         q[$];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_pc = 0; m_mode = 0; m_pos = 0; m_streak = 0; m_last = 0; m_quiet = 0;
            m_ovf = 0; m_s1 = '0; m_s2 = '0;
            q.delete();
        end else begin
            m_rs   = m_s2;
            m_tick = m_pc == CLK_DIV - 1;
            m_pc   = (m_pc + 1) % CLK_DIV;
            m_push = 0;
            if (m_tick) begin
                if (m_mode == 0) begin
                    if (m_rs != 0) begin
                        m_mode = 1;
                        m_pos  = 0;
                    end
                end else if (m_mode == 1) begin
                    m_samp[m_pos] = m_rs;
                    if (m_pos < 3) m_pos++;
                    else begin
                        m_pos = 0;
                        m_total = 0;
                        for (int c = 0; c < 4; c++)
                            for (int r = 0; r < 4; r++)
                                if (m_samp[c][r]) begin
                                    m_total++;
                                    m_code = 4*r + c;
                                end
                        if (m_total == 0) begin
                            m_mode = 0;
                            m_streak = 0;
                        end else if (m_total > 1) m_streak = 0;
                        else begin
                            m_streak = (m_code == m_last) ? m_streak + 1 : 1;
                            m_last = m_code;
                            if (m_streak == DEBOUNCE) begin
                                m_push = 1;
                                m_mode = 2;
                                m_streak = 0;
                            end
                        end
                    end
                end else begin
                    m_quiet = (m_rs == 0) ? m_quiet + 1 : 0;
                    if (m_quiet == DEBOUNCE) begin
                        m_mode = 0;
                        m_quiet = 0;
                    end
                end
            end
            m_drop = 0;
            if (key_rd && q.size() > 0) void'(q.pop_front());
            if (m_push) begin
                if (q.size() < FIFO_DEPTH) q.push_back(m_last);
                else m_drop = 1;
            end
            m_ovf = m_drop ? 1'b1 : ovf_clr ? 1'b0 : m_ovf;
            m_s2 = m_s1;
            m_s1 = row;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("col", 32'(col), m_mode == 1 ? 32'(1 << m_pos) : 32'd15);
        chk("key_down", 32'(key_down), 32'(m_mode == 2));
        chk("key_valid", 32'(key_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("key_code", 32'(key_code), 32'(q[0]));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    end

    task automatic wait_down(input logic v);
        int n = 0;
        while (key_down !== v && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("wait_key_down", 32'(key_down), 32'(v));
    endtask

    task automatic wait_col(input logic [3:0] v);
        int n = 0;
        while (col !== v && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("wait_col", 32'(col), 32'(v));
    endtask

    task automatic press_release(input int code);
        keys = 16'(1) << code;
        wait_down(1'b1);
        keys = '0;
        wait_down(1'b0);
    endtask

    task automatic pop(input int exp);
        chk("pop_code", 32'(key_code), 32'(exp));
        chk("pop_valid", 32'(key_valid), 32'd1);
        key_rd = 1'b1;
        @(negedge clk);
        key_rd = 1'b0;
    endtask

    int ovf_codes[5] = '{0, 3, 12, 15, 6};
    int fill_codes[4] = '{1, 2, 4, 8};

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_col", 32'(col), 32'd15);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_down", 32'(key_down), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_code", 32'(key_code), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // clean press of key 9 (row 2, column 1)
        keys = 16'(1) << 9;
        wait_down(1'b1);
        chk("clean_code", 32'(key_code), 32'd9);
        chk("clean_valid", 32'(key_valid), 32'd1);
        repeat (4*CLK_DIV) @(negedge clk);
        chk("clean_still_down", 32'(key_down), 32'd1);
        keys = '0;
        wait_down(1'b0);
        pop(9);
        chk("clean_single", 32'(key_valid), 32'd0);

        // bounce: key 5 present in sweep 1, gone in sweep 2
        keys = 16'(1) << 5;
        wait_col(4'b0001);
        wait_col(4'b0010);
        wait_col(4'b0001);
        keys = '0;
        wait_col(4'b1111);
        chk("bounce_no_push", 32'(key_valid), 32'd0);
        chk("bounce_not_down", 32'(key_down), 32'd0);
        keys = 16'(1) << 5;
        wait_down(1'b1);
        keys = '0;
        wait_down(1'b0);
        pop(5);
        chk("bounce_single", 32'(key_valid), 32'd0);

        // ghost: keys 0 and 4 both on column 0
        keys = 16'h0011;
        wait_col(4'b0001);
        repeat (16*CLK_DIV) @(negedge clk);
        chk("ghost_no_valid", 32'(key_valid), 32'd0);
        chk("ghost_scanning", 32'(col != 4'b1111), 32'd1);
        chk("ghost_not_down", 32'(key_down), 32'd0);
        keys = '0;
        wait_col(4'b1111);

        // overflow with five presses and no reads
        for (int i = 0; i < 5; i++) press_release(ovf_codes[i]);
        chk("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) pop(ovf_codes[i]);
        chk("ovf_drained", 32'(key_valid), 32'd0);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // overflowing push with ovf_clr high on the same edge
        for (int i = 0; i < 4; i++) press_release(fill_codes[i]);
        chk("full_no_ovf", 32'(overflow), 32'd0);
        ovf_clr = 1'b1;
        keys = 16'(1) << 9;
        wait_down(1'b1);
        ovf_clr = 1'b0;
        chk("ovf_set_beats_clr", 32'(overflow), 32'd1);
        keys = '0;
        wait_down(1'b0);

        // pop coinciding with a push into a full FIFO
        keys = 16'(1) << 13;
        wait_col(4'b0001);
        wait_col(4'b1000);
        wait_col(4'b0001);
        wait_col(4'b1000);
        repeat (CLK_DIV - 1) @(negedge clk);
        chk("coinc_pre_down", 32'(key_down), 32'd0);
        key_rd = 1'b1;
        @(negedge clk);
        key_rd = 1'b0;
        chk("coinc_down", 32'(key_down), 32'd1);
        chk("coinc_ovf", 32'(overflow), 32'd1);
        keys = '0;
        wait_down(1'b0);
        pop(2);
        pop(4);
        pop(8);
        pop(13);
        chk("coinc_count4", 32'(key_valid), 32'd0);

        // asynchronous reset mid-scan with two entries queued
        press_release(7);
        press_release(10);
        keys = 16'(1) << 1;
        wait_col(4'b0010);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_col", 32'(col), 32'd15);
        chk("arst_valid", 32'(key_valid), 32'd0);
        chk("arst_code", 32'(key_code), 32'd0);
        chk("arst_down", 32'(key_down), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        keys = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2*CLK_DIV) @(negedge clk);
        chk("post_rst_col", 32'(col), 32'd15);
        chk("post_rst_valid", 32'(key_valid), 32'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

endmodule
